// File: rtl/analog_pad_sequencer_if.sv
// Wishbone slave bundle for the analog pad sequencer. Signal names keep the
// slave-side direction suffixes so they match the user-project wrapper.
interface analog_pad_sequencer_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/analog_pad_sequencer.sv
// Wishbone-controlled pad-mode sequencer for the opamp pads. Pads come out of
// reset clamped (driver on, low) and are released to analog one at a time,
// lowest index first, with a programmable dwell per step; clamping runs in
// reverse. Registers: +0x0 CTRL, +0x4 MASK, +0x8 DWELL, +0xC STATUS.
module analog_pad_sequencer #(
    parameter logic [31:0]        BASE_ADDR = 32'h3000_0100,
    parameter int                 NPADS     = 6,
    parameter int                 DWELL_W   = 16,
    parameter logic [DWELL_W-1:0] DWELL_RST = 16'd100
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    analog_pad_sequencer_if.slave  wb,
    output logic [NPADS-1:0]       pad_out,
    output logic [NPADS-1:0]       pad_oeb,
    output logic                   seq_irq
);

    // Step index is reported in a 3-bit STATUS field, so NPADS must be <= 8.
    localparam int STEP_W = 3;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NPADS - 1);

    typedef enum logic [1:0] {
        ST_CLAMPED = 2'd0,
        ST_RELEASE = 2'd1,
        ST_ANALOG  = 2'd2,
        ST_CLAMP   = 2'd3
    } state_e;

    // Sequencer state
    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [NPADS-1:0]   pad_oeb_q, pad_oeb_d;
    logic [NPADS-1:0]   mask_lat_q, mask_lat_d;
    logic               irq_set;
    logic               step_done;

    // Register file and bus state
    logic               ctrl_en_q, ctrl_en_d;
    logic [NPADS-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               irq_q, irq_d;
    logic               irq_clr;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic               hit, access, wr_acc, rd_acc, busy;
    logic [31:0]        rdata, merged, status;
    logic [DWELL_W-1:0] dwell_eff;
    logic               unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign hit    = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // One-cycle ack with a mandatory gap: a held strobe is served every other cycle.
    assign access = hit & ~ack_q;
    assign wr_acc = access &  wb.wbs_we_i;
    assign rd_acc = access & ~wb.wbs_we_i;
    assign busy   = (state_q == ST_RELEASE) || (state_q == ST_CLAMP);

    // A programmed dwell of zero behaves as one cycle per step.
    assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

    // Register read mux and STATUS packing.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise an unassigned path infers a latch.
        status              = '0;
        status[1:0]         = state_q;
        status[2]           = busy;
        status[5:3]         = step_q;
        status[8 +: NPADS]  = pad_oeb_q;
        status[16]          = irq_q;
        rdata               = '0;
        case (wb.wbs_adr_i[3:2])
            2'd0:    rdata = {31'b0, ctrl_en_q};
            2'd1:    rdata = 32'(mask_q);
            2'd2:    rdata = 32'(dwell_q);
            default: rdata = status;
        endcase
    end

    // Byte-lane write decode; the old value of the selected register is the merge base.
    always_comb begin
        merged    = merge_bytes(rdata, wb.wbs_dat_i, wb.wbs_sel_i);
        ctrl_en_d = ctrl_en_q;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        irq_clr   = 1'b0;
        if (wr_acc) begin
            case (wb.wbs_adr_i[3:2])
                2'd0: begin
                    ctrl_en_d = merged[0];
                    irq_clr   = merged[1];
                end
                2'd1:    if (!busy) mask_d = merged[NPADS-1:0];
                2'd2:    dwell_d = merged[DWELL_W-1:0];
                default: ;
            endcase
        end
        ack_d = access;
        dat_d = rd_acc ? rdata : '0;
        irq_d = irq_set ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    end

    assign unused_bits = ^{wb.wbs_adr_i[1:0], merged[31:16]};

    // Sequencer next-state: one pad per step, masked-out steps skip in one cycle.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        pad_oeb_d  = pad_oeb_q;
        mask_lat_d = mask_lat_q;
        irq_set    = 1'b0;
        step_done  = 1'b0;
        case (state_q)
            ST_CLAMPED: begin
                if (ctrl_en_q) begin
                    state_d    = ST_RELEASE;
                    step_d     = '0;
                    cnt_d      = dwell_eff;
                    mask_lat_d = mask_q;
                end
            end
            ST_RELEASE: begin
                if (!ctrl_en_q) begin
                    state_d = ST_CLAMP;
                    cnt_d   = dwell_eff;
                end else begin
                    if (mask_lat_q[step_q]) begin
                        pad_oeb_d[step_q] = 1'b1;
                        cnt_d             = cnt_q - DWELL_W'(1);
                        step_done         = (cnt_q <= DWELL_W'(1));
                    end else begin
                        step_done = 1'b1;
                    end
                    if (step_done) begin
                        cnt_d = dwell_eff;
                        if (step_q == LAST_STEP) begin
                            state_d = ST_ANALOG;
                            irq_set = 1'b1;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end
                end
            end
            ST_ANALOG: begin
                if (!ctrl_en_q) begin
                    state_d    = ST_CLAMP;
                    step_d     = LAST_STEP;
                    cnt_d      = dwell_eff;
                    mask_lat_d = mask_q;
                end
            end
            default: begin // ST_CLAMP
                if (ctrl_en_q) begin
                    state_d = ST_RELEASE;
                    cnt_d   = dwell_eff;
                end else begin
                    if (mask_lat_q[step_q]) begin
                        pad_oeb_d[step_q] = 1'b0;
                        cnt_d             = cnt_q - DWELL_W'(1);
                        step_done         = (cnt_q <= DWELL_W'(1));
                    end else begin
                        step_done = 1'b1;
                    end
                    if (step_done) begin
                        cnt_d = dwell_eff;
                        if (step_q == '0) begin
                            state_d   = ST_CLAMPED;
                            pad_oeb_d = '0;
                            irq_set   = 1'b1;
                        end else begin
                            step_d = step_q - STEP_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!wb_rst_n_i) begin
            state_q    <= ST_CLAMPED;
            step_q     <= '0;
            cnt_q      <= '0;
            pad_oeb_q  <= '0;
            mask_lat_q <= '0;
            ctrl_en_q  <= 1'b0;
            mask_q     <= '1;
            dwell_q    <= DWELL_RST;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            pad_oeb_q  <= pad_oeb_d;
            mask_lat_q <= mask_lat_d;
            ctrl_en_q  <= ctrl_en_d;
            mask_q     <= mask_d;
            dwell_q    <= dwell_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign pad_out      = '0;
    assign pad_oeb      = pad_oeb_q;
    assign seq_irq      = irq_q;

endmodule

// File: tb/tb_analog_pad_sequencer.sv
// Directed bench for analog_pad_sequencer: register access, release/clamp
// timing, masking, reversal, zero dwell, busy write drop and mid-run reset.
module tb_analog_pad_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_MASK = BASE + 32'h4;
    localparam logic [31:0] A_DWEL = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] pad_out, pad_oeb;
    logic       seq_irq;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [31:0] rd;

    analog_pad_sequencer_if wb ();

    analog_pad_sequencer dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb),
        .pad_out    (pad_out),
        .pad_oeb    (pad_oeb),
        .seq_irq    (seq_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] byte_sel);
        bit got;
        got = 1'b0;
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
        wb.wbs_adr_i = addr; wb.wbs_dat_i = data; wb.wbs_sel_i = byte_sel;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) got = 1'b1;
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        check("wr_ack", 32'(got), 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] data);
        bit got;
        got  = 1'b0;
        data = 32'hDEAD_BEEF;
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = addr; wb.wbs_sel_i = 4'hF;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) begin
                got  = 1'b1;
                data = wb.wbs_dat_o;
            end
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        check("rd_ack", 32'(got), 32'd1);
    endtask

    // Hold a strobe for n cycles and count acks and back-to-back acks.
    task automatic wb_hold(input logic [31:0] addr, input int n,
                           output int acks, output int b2b);
        bit prev;
        acks = 0; b2b = 0; prev = 1'b0;
        @(negedge clk);
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = addr; wb.wbs_sel_i = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) begin
                acks++;
                if (prev) b2b++;
            end
            prev = wb.wbs_ack_o;
        end
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        tick(1);
    endtask

    task automatic wait_clamped(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick(1);
            if (pad_oeb == 6'h00 && seq_irq) done = 1'b1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, b2b;
        logic [5:0] exp_pad;
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;

        // Reset state
        tick(3);
        check("rst_pad_oeb", 32'(pad_oeb), 32'h0);
        check("rst_ack", 32'(wb.wbs_ack_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("rst_pad_out", 32'(pad_out), 32'h0);
        check("rst_irq", 32'(seq_irq), 32'h0);
        check("rst_dat_o", wb.wbs_dat_o, 32'h0);
        wb_read(A_CTRL, rd);  check("rst_ctrl", rd, 32'h0);
        wb_read(A_MASK, rd);  check("rst_mask", rd, 32'h3F);
        wb_read(A_DWEL, rd);  check("rst_dwell", rd, 32'd100);
        wb_read(A_STAT, rd);  check("rst_status", rd, 32'h0);
        check("idle_pad_oeb", 32'(pad_oeb), 32'h0);

        // Bus protocol: held strobe acks every other cycle; misses never ack
        wb_hold(A_MASK, 4, acks, b2b);
        check("hold_acks", 32'(acks), 32'd2);
        check("hold_b2b", 32'(b2b), 32'd0);
        wb_hold(BASE + 32'h10, 4, acks, b2b);
        check("miss_acks", 32'(acks), 32'd0);

        // Full release, DWELL=4: pads every 4 cycles, first 2 cycles after ack edge
        wb_write(A_DWEL, 32'd4, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        tick(1);  check("rel_lat1", 32'(pad_oeb), 32'h00);
        tick(1);  check("rel_lat2", 32'(pad_oeb), 32'h01);
        exp_pad = 6'h01;
        for (int k = 1; k < 6; k++) begin
            tick(3);  check("rel_hold", 32'(pad_oeb), 32'(exp_pad));
            exp_pad = {exp_pad[4:0], 1'b1};
            tick(1);  check("rel_step", 32'(pad_oeb), 32'(exp_pad));
        end
        tick(2);  check("rel_irq_pre", 32'(seq_irq), 32'h0);
        tick(1);  check("rel_irq", 32'(seq_irq), 32'h1);
        wb_read(A_STAT, rd);  check("rel_status", rd, 32'h0001_3F2A);

        // Clear irq keeping EN, then clamp everything back
        wb_write(A_CTRL, 32'h3, 4'hF);
        check("irq_clear", 32'(seq_irq), 32'h0);
        wb_write(A_CTRL, 32'h0, 4'hF);
        wait_clamped("clamp_done", 200);
        wb_write(A_CTRL, 32'h2, 4'hF);
        check("irq_clear2", 32'(seq_irq), 32'h0);

        // Masked release: MASK=0x24, DWELL=3 -> 10 cycles from entry to ANALOG
        wb_write(A_MASK, 32'h24, 4'hF);
        wb_write(A_DWEL, 32'd3, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        tick(3);  check("msk_skip", 32'(pad_oeb), 32'h00);
        tick(1);  check("msk_pad2", 32'(pad_oeb), 32'h04);
        tick(4);  check("msk_hold", 32'(pad_oeb), 32'h04);
        tick(1);  check("msk_pad5", 32'(pad_oeb), 32'h24);
        tick(1);  check("msk_irq_pre", 32'(seq_irq), 32'h0);
        tick(1);  check("msk_irq", 32'(seq_irq), 32'h1);
        wb_write(A_CTRL, 32'h2, 4'hF);
        wait_clamped("msk_clamp_done", 100);
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_write(A_MASK, 32'h3F, 4'hF);

        // Reversal: drop EN after pad 2 released
        wb_write(A_DWEL, 32'd4, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        tick(10); check("rev_pad2", 32'(pad_oeb), 32'h07);
        wb_write(A_CTRL, 32'h0, 4'hF);
        tick(1);  check("rev_enter", 32'(pad_oeb), 32'h07);
        tick(1);  check("rev_c2", 32'(pad_oeb), 32'h03);
        tick(4);  check("rev_c1", 32'(pad_oeb), 32'h01);
        tick(4);  check("rev_c0", 32'(pad_oeb), 32'h00);
        tick(2);  check("rev_irq_pre", 32'(seq_irq), 32'h0);
        tick(1);  check("rev_irq", 32'(seq_irq), 32'h1);
        wb_read(A_STAT, rd);  check("rev_status", rd, 32'h0001_0000);
        wb_write(A_CTRL, 32'h2, 4'hF);

        // DWELL=0 behaves as 1: one pad per cycle
        wb_write(A_DWEL, 32'd0, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        tick(1);  check("z_enter", 32'(pad_oeb), 32'h00);
        exp_pad = 6'h00;
        for (int k = 0; k < 6; k++) begin
            exp_pad = {exp_pad[4:0], 1'b1};
            tick(1);  check("z_step", 32'(pad_oeb), 32'(exp_pad));
        end
        check("z_irq", 32'(seq_irq), 32'h1);

        // Byte-lane write on DWELL
        wb_write(A_DWEL, 32'h32, 4'hF);
        wb_write(A_DWEL, 32'h0000_AB77, 4'h2);
        wb_read(A_DWEL, rd);  check("dwell_sel", rd, 32'h0000_AB32);
        wb_write(A_DWEL, 32'd50, 4'hF);

        // MASK write while busy is dropped
        wb_write(A_CTRL, 32'h2, 4'hF);
        wb_write(A_MASK, 32'h01, 4'hF);
        wb_read(A_MASK, rd);  check("busy_mask", rd, 32'h3F);
        wb_read(A_STAT, rd);  check("busy_state", rd & 32'h7, 32'h7);
        wait_clamped("busy_clamp_done", 600);

        // Reset during RELEASE at pad_oeb=0x0F with a read in flight
        wb_write(A_DWEL, 32'd4, 4'hF);
        wb_write(A_CTRL, 32'h1, 4'hF);
        tick(14); check("mr_pad", 32'(pad_oeb), 32'h0F);
        @(negedge clk);
        rst_n = 1'b0;
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = A_STAT; wb.wbs_sel_i = 4'hF;
        tick(1);
        check("mr_pad_clr", 32'(pad_oeb), 32'h00);
        check("mr_ack", 32'(wb.wbs_ack_o), 32'h0);
        check("mr_irq", 32'(seq_irq), 32'h0);
        tick(1);
        check("mr_ack2", 32'(wb.wbs_ack_o), 32'h0);
        @(negedge clk);
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        rst_n = 1'b1;
        wb_read(A_CTRL, rd);  check("mr_ctrl", rd, 32'h0);
        wb_read(A_MASK, rd);  check("mr_mask", rd, 32'h3F);
        wb_read(A_DWEL, rd);  check("mr_dwell", rd, 32'd100);
        wb_read(A_STAT, rd);  check("mr_status", rd, 32'h0);
        tick(5);  check("mr_pad_idle", 32'(pad_oeb), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
